// File: rtl/archie_loader_pkg.sv
// Shared types for the ioctl -> Wishbone download loader.
//   entry_t    : one buffered write (word address, byte selects, data)
//   wb_state_t : Wishbone master state
//   SEL_LO/HI  : the two halfword byte-lane patterns the HPS can send
package archie_loader_pkg;

    localparam int ADR_W = 23;

    localparam logic [3:0] SEL_LO = 4'b0011;
    localparam logic [3:0] SEL_HI = 4'b1100;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [3:0]       sel;
        logic [31:0]      dat;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic {IDLE, WRITE} wb_state_t;

endpackage

// File: rtl/ioctl_wb_loader_if.sv
// Single-beat Wishbone write bus between the loader (master) and the
// main-memory controller (slave).
//   wb_cyc/wb_stb/wb_we : cycle, strobe, write enable (master)
//   wb_adr/wb_sel/wb_dat_o : word address, byte selects, write data (master)
//   wb_ack : slave acknowledge
interface ioctl_wb_loader_if #(
    parameter int WB_AW = 23
);
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [WB_AW-1:0] wb_adr;
    logic [3:0]       wb_sel;
    logic [31:0]      wb_dat_o;
    logic             wb_ack;

    modport master (output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o,
                    input  wb_ack);
    modport slave  (input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o,
                    output wb_ack);
endinterface

// File: rtl/loader_fifo.sv
// Synchronous FIFO with first-word-fall-through read and occupancy count.
//   push/din  : write request and data
//   pop       : consume head (ignored when empty)
//   dout      : current head entry
//   empty/full/count : occupancy
// A push while full is accepted only if a pop happens in the same cycle.
module loader_fifo #(
    parameter  int FIFO_DEPTH = 8,
    parameter  int WIDTH      = 59,
    localparam int PW         = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [PW:0]      count
);
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB separates full from empty when the low bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
    end
endmodule

// File: rtl/ioctl_wb_loader.sv
// HPS file-download write path into Archie main memory.
// Buffers halfword ioctl writes in a FIFO and replays each as a single-beat
// Wishbone write; throttles the HPS with ioctl_wait and reports completion
// and dropped writes.
//   clk_sys, reset       : clock, async active-high reset
//   ioctl_*              : HPS download strobe/address/data/lanes, wait back
//   wb (master)          : Wishbone write bus
//   loader_busy/done     : activity level and one-cycle drained pulse
//   overflow, beat_count : sticky drop flag and acked-beat counter
// Build option IOCTL_WB_MERGE_EN: pair complementary halfwords to the same
// word in a one-entry merge register and issue one 32-bit beat for them.
module ioctl_wb_loader
    import archie_loader_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int WAIT_MARGIN = 2,
    parameter int WB_AW       = 23
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [31:0] ioctl_dout,
    input  logic [3:0]  ioctl_sel,
    output logic        ioctl_wait,
    ioctl_wb_loader_if.master wb,
    output logic        loader_busy,
    output logic        loader_done,
    output logic        overflow,
    output logic [23:0] beat_count
);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int WAIT_AT = FIFO_DEPTH - WAIT_MARGIN;

    entry_t       in_ent, push_ent, head;
    logic         push, pop, load, empty, full;
    logic [PW:0]  count;
    logic         held_cnt;
    logic         dl_rise;
    logic         unused_addr;

    wb_state_t    state_q, state_d;
    logic         cyc_q, cyc_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [3:0]   sel_q, sel_d;
    logic [31:0]  dat_q, dat_d;
    logic [23:0]  beat_q, beat_d;
    logic         ovf_q, ovf_d;
    logic         wait_q, wait_d;
    logic         dl_q, busy_q;

    assign in_ent      = '{adr: ioctl_addr[24:2], sel: ioctl_sel, dat: ioctl_dout};
    assign unused_addr = &{1'b0, ioctl_addr[1:0]};

`ifdef IOCTL_WB_MERGE_EN
    entry_t held_q, held_d;
    logic   held_vld_q, held_vld_d;
    logic   held_match;

    assign held_match = held_vld_q && (held_q.adr == in_ent.adr) &&
                        (held_q.sel == ~in_ent.sel);
    assign held_cnt   = held_vld_q;

    always_comb begin
        held_d     = held_q;
        held_vld_d = held_vld_q;
        push       = 1'b0;
        push_ent   = held_q;
        if (ioctl_wr) begin
            if (held_match) begin
                push         = 1'b1;
                push_ent.sel = 4'b1111;
                push_ent.dat = (held_q.sel == SEL_LO) ?
                               {in_ent.dat[31:16], held_q.dat[15:0]} :
                               {held_q.dat[31:16], in_ent.dat[15:0]};
                held_vld_d   = 1'b0;
            end else begin
                push       = held_vld_q;
                held_d     = in_ent;
                held_vld_d = 1'b1;
            end
        end else if (held_vld_q && !ioctl_download) begin
            // Outside the download window nothing more will pair up: flush
            // on the first write-free cycle.
            push       = 1'b1;
            held_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            held_q     <= '0;
            held_vld_q <= 1'b0;
        end else begin
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
        end
    end
`else
    assign push     = ioctl_wr;
    assign push_ent = in_ent;
    assign held_cnt = 1'b0;
`endif

    loader_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign dl_rise = ioctl_download && !dl_q;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        load    = 1'b0;
        pop     = 1'b0;
        beat_d  = dl_rise ? '0 : beat_q;
        ovf_d   = dl_rise ? 1'b0 : ovf_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (wb.wb_ack) begin
                    if (beat_d != '1) beat_d = beat_d + 24'd1;
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cyc_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            pop   = 1'b1;
            cyc_d = 1'b1;
            adr_d = head.adr;
            sel_d = head.sel;
            dat_d = head.dat;
        end
        // A pop in the same cycle frees the slot, so only an unpaired full push drops.
        if (push && full && !pop) ovf_d = 1'b1;
        wait_d = ioctl_download && ((int'(count) + int'(held_cnt)) >= WAIT_AT);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            beat_q  <= '0;
            ovf_q   <= 1'b0;
            wait_q  <= 1'b0;
            dl_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
            wait_q  <= wait_d;
            dl_q    <= ioctl_download;
            busy_q  <= loader_busy;
        end
    end

    assign wb.wb_cyc   = cyc_q;
    assign wb.wb_stb   = cyc_q;
    assign wb.wb_we    = cyc_q;
    assign wb.wb_adr   = WB_AW'(adr_q);
    assign wb.wb_sel   = sel_q;
    assign wb.wb_dat_o = dat_q;

    // The wait flop lags the window by a cycle; gate it so the HPS never
    // sees a stall outside the window.
    assign ioctl_wait  = wait_q && ioctl_download;
    assign loader_busy = !reset && (ioctl_download || !empty || held_cnt ||
                                    (state_q == WRITE));
    assign loader_done = busy_q && !loader_busy;
    assign overflow    = ovf_q;
    assign beat_count  = beat_q;
endmodule

// File: tb/tb_ioctl_wb_loader.sv
module tb_ioctl_wb_loader;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [31:0] ioctl_dout = '0;
    logic [3:0]  ioctl_sel = '0;
    logic        ioctl_wait, loader_busy, loader_done, overflow;
    logic [23:0] beat_count;
    logic        ack_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [58:0] beats[$];

    ioctl_wb_loader_if #(.WB_AW(23)) bus();

    ioctl_wb_loader #(.FIFO_DEPTH(8), .WAIT_MARGIN(2), .WB_AW(23)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_sel      (ioctl_sel),
        .ioctl_wait     (ioctl_wait),
        .wb             (bus.master),
        .loader_busy    (loader_busy),
        .loader_done    (loader_done),
        .overflow       (overflow),
        .beat_count     (beat_count)
    );

    always #5 clk_sys = ~clk_sys;

    // Slave: acks in the cycle after it sees the strobe, when enabled.
    always @(posedge clk_sys or posedge reset) begin
        if (reset) bus.wb_ack <= 1'b0;
        else       bus.wb_ack <= ack_en && bus.wb_cyc && bus.wb_stb && !bus.wb_ack;
    end

    always @(posedge clk_sys) begin
        if (!reset && bus.wb_cyc && bus.wb_stb && bus.wb_ack)
            beats.push_back({bus.wb_adr, bus.wb_sel, bus.wb_dat_o});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic drive_wr(input logic [24:0] a, input logic [15:0] h);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = {h, h};
        ioctl_sel  = a[1] ? 4'b1100 : 4'b0011;
    endtask

    // Done is sampled 1 time unit after the falling edge so a download
    // drop made at that edge has settled.
    task automatic wait_done(input string tag);
        int n = 0;
        #1;
        while (!loader_done && n < 300) begin
            @(negedge clk_sys); #1;
            n++;
        end
        chk({tag, "_done_seen"}, loader_done, 1);
        @(negedge clk_sys); #1;
        chk({tag, "_done_1cyc"}, loader_done, 0);
        chk({tag, "_idle"}, loader_busy, 0);
    endtask

    task automatic chk_beats(input string tag, input logic [24:0] base,
                             input logic [15:0] h0, input logic [15:0] step, input int n);
        logic [24:0] a;
        logic [15:0] h;
        logic [3:0]  s;
        chk({tag, "_nbeats"}, beats.size(), n);
        for (int i = 0; i < n && i < beats.size(); i++) begin
            a = base + 25'(2 * i);
            h = h0 + 16'(i) * step;
            s = a[1] ? 4'b1100 : 4'b0011;
            chk($sformatf("%s_beat%0d", tag, i), beats[i], {a[24:2], s, h, h});
        end
    endtask

    initial begin
        int issued, wait_at, acks, ack_last, done_at, ndone, busy_gap, bad;

        // Reset state
        tick(2);
        chk("rst_cyc", bus.wb_cyc, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_busy", loader_busy, 0);
        chk("rst_done", loader_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_beats", beat_count, 0);
        reset = 1'b0;
        tick();

        // 1: four halfwords, prompt slave
        beats.delete();
        ack_en = 1'b1;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_wr(25'h400000 + 25'(2 * i), 16'h1111 * 16'(i + 1));
            tick();
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        wait_done("t1");
        chk_beats("t1", 25'h400000, 16'h1111, 16'h1111, 4);
        chk("t1_count", beat_count, 4);
        chk("t1_ovf", overflow, 0);

        // 2: slave stalls 20 cycles, HPS honours wait
        beats.delete();
        ack_en = 1'b0;
        ioctl_download = 1'b1;
        tick();
        issued = 0;
        wait_at = -1;
        for (int c = 0; c < 200; c++) begin
            if (c == 20) ack_en = 1'b1;
            if (ioctl_wait && wait_at < 0) wait_at = issued;
            if (!ioctl_wait && issued < 12) begin
                drive_wr(25'h000100 + 25'(2 * issued), 16'hA000 + 16'(issued));
                issued++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
        end
        ioctl_wr = 1'b0;
        // One beat sits on the bus, so the queue reaches 6 after the 7th write;
        // wait is seen before the 9th.
        chk("t2_wait_at", wait_at, 8);
        chk("t2_issued", issued, 12);
        chk("t2_ovf", overflow, 0);
        ioctl_download = 1'b0;
        wait_done("t2");
        chk_beats("t2", 25'h000100, 16'hA000, 16'h0001, 12);
        chk("t2_count", beat_count, 12);

        // 3: slave stalls, HPS ignores wait: bus beat + 8 queued survive
        beats.delete();
        ack_en = 1'b0;
        ioctl_download = 1'b1;
        tick();
        issued = 0;
        for (int c = 0; c < 80; c++) begin
            if (c == 20) ack_en = 1'b1;
            if (issued < 12) begin
                drive_wr(25'h000200 + 25'(2 * issued), 16'hB000 + 16'(issued));
                issued++;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
        end
        chk("t3_ovf_set", overflow, 1);
        ioctl_download = 1'b0;
        wait_done("t3");
        chk_beats("t3", 25'h000200, 16'hB000, 16'h0001, 9);
        chk("t3_ovf_sticky", overflow, 1);
        ioctl_download = 1'b1;
        tick();
        chk("t3_ovf_clear", overflow, 0);
        chk("t3_count_clear", beat_count, 0);

        // 4: download ends with three writes outstanding
        beats.delete();
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_wr(25'h000300 + 25'(2 * i), 16'hC000 + 16'(i));
            tick();
        end
        ioctl_wr = 1'b0;
        tick(2);
        ioctl_download = 1'b0;
        tick();
        chk("t4_busy_hold", loader_busy, 1);
        tick(3);
        chk("t4_busy_hold2", loader_busy, 1);
        ack_en = 1'b1;
        acks = 0; ack_last = -1; done_at = -1; ndone = 0; busy_gap = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.wb_ack && bus.wb_cyc) begin
                acks++;
                if (acks == 3) ack_last = c;
            end
            if (loader_done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (!loader_busy && ack_last < 0) busy_gap = 1;
        end
        chk("t4_acks", acks, 3);
        chk("t4_busy_gap", busy_gap, 0);
        chk("t4_done_timing", done_at, ack_last + 1);
        chk("t4_done_pulses", ndone, 1);
        chk("t4_count", beat_count, 3);

        // 5: reset in the middle of a pending beat
        ack_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_wr(25'h000400 + 25'(2 * i), 16'hE000 + 16'(i));
            tick();
        end
        ioctl_wr = 1'b0;
        tick(2);
        chk("t5_cyc_before", bus.wb_cyc, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_cyc_async", bus.wb_cyc, 0);
        chk("t5_stb_async", bus.wb_stb, 0);
        chk("t5_busy", loader_busy, 0);
        chk("t5_done", loader_done, 0);
        chk("t5_count", beat_count, 0);
        tick();
        reset = 1'b0;
        ack_en = 1'b1;
        beats.delete();
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.wb_cyc || loader_done || loader_busy) bad = 1;
        end
        chk("t5_empty_after", bad, 0);
        chk("t5_no_beats", beats.size(), 0);

        // 6: push while full in the same cycle as a pop
        beats.delete();
        ack_en = 1'b0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            drive_wr(25'h000500 + 25'(2 * i), 16'hD000 + 16'(i));
            tick();
        end
        ioctl_wr = 1'b0;
        tick();
        chk("t6_fill_no_ovf", overflow, 0);
        chk("t6_wait_full", ioctl_wait, 1);
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        chk("t6_ack_now", bus.wb_ack, 1);
        drive_wr(25'h000500 + 25'(2 * 9), 16'hD000 + 16'(9));
        tick();
        ioctl_wr = 1'b0;
        chk("t6_simul_no_ovf", overflow, 0);
        drive_wr(25'h000500 + 25'(2 * 10), 16'hD000 + 16'(10));
        tick();
        ioctl_wr = 1'b0;
        tick();
        chk("t6_still_full", overflow, 1);
        ack_en = 1'b1;
        ioctl_download = 1'b0;
        wait_done("t6");
        chk_beats("t6", 25'h000500, 16'hD000, 16'h0001, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ioctl_wb_loader.md
Name: ioctl_wb_loader

Overview:
Downstream stage of the HPS I/O block's file-download channel.
- Accepts halfword ioctl write strobes (16-bit data replicated on both halves of a 32-bit bus, plus a byte-lane select) and buffers them in a small FIFO.
- Replays each buffered write as a single-beat Wishbone write into the Archie main-memory controller.
- Throttles the HPS through ioctl_wait, and reports completion and overflow to the loader control logic.

Parameters:
- FIFO_DEPTH, 8, number of FIFO entries. Must be a power of 2 and at least 4.
- WAIT_MARGIN, 2, free-slot threshold for asserting ioctl_wait. Covers the HPS round-trip latency.
- WB_AW, 23, Wishbone word-address width. Equals byte address bits [24:2].

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  25  byte address; even, advances by 2.
- ioctl_dout  in  32  write data; halfword replicated on both halves.
- ioctl_sel  in  4  byte lanes: 4'b0011 or 4'b1100.
- ioctl_wait  out  1  stall request to the HPS.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  write enable; constant 1 while cyc is high.
- wb_adr  out  WB_AW  word address.
- wb_sel  out  4  byte selects.
- wb_dat_o  out  32  write data.
- wb_ack  in  1  slave acknowledge.
- loader_busy  out  1  download active, or FIFO/bus not yet drained.
- loader_done  out  1  one-cycle pulse when a download has fully drained.
- overflow  out  1  sticky flag: a write was dropped.
- beat_count  out  24  number of Wishbone writes acknowledged in the current download.

Behaviour:

Reset
- Asynchronous, active-high; the interface is one clock (clk_sys) with this fixed reset.
- While reset is asserted: all outputs are 0 and the FIFO is empty.
- wb_cyc and wb_stb drop immediately, even in the middle of a transfer. The interrupted beat is lost, not retried.

Push path
- On ioctl_wr, the entry {ioctl_addr[24:2], ioctl_sel, ioctl_dout} is written into the FIFO at wr_ptr.
- If the FIFO is full, the entry is dropped and overflow is set to 1.

FIFO
- wr_ptr and rd_ptr are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
- Empty: pointers are equal.
- Full: MSBs differ and the low bits are equal.
- Simultaneous push and pop leave the count unchanged. This is legal even when the FIFO is full: the pop frees a slot in the same cycle, so the push is accepted.

Flow control
- ioctl_wait is registered: it is 1 in the cycle after count >= FIFO_DEPTH - WAIT_MARGIN, and 0 in the cycle after count falls below that threshold.
- ioctl_wait is never asserted while ioctl_download is 0.

Wishbone state machine
- States: IDLE, WRITE.
- IDLE -> WRITE when the FIFO is not empty. In that cycle the head entry is loaded into the wb_* registers, the entry is popped, and wb_cyc = wb_stb = wb_we = 1.
- WRITE holds all signals stable until wb_ack is 1. On the ack, beat_count increments.
  - If the FIFO is non-empty in the ack cycle: the next entry is loaded and the machine stays in WRITE. Back-to-back beats are allowed with 0 idle cycles.
  - Otherwise: go to IDLE and deassert cyc, stb and we.
- wb_ack arriving in IDLE is ignored.

Download window and completion
- On a rising edge of ioctl_download: overflow and beat_count are cleared.
- loader_busy = ioctl_download | FIFO not empty | (state == WRITE).
- loader_done pulses for one cycle on the falling edge of loader_busy, i.e. one cycle after the last ack once download has ended.
- If download ends while the FIFO still holds entries, they drain normally. Writes arriving after download ends are still accepted.
- beat_count saturates at all-ones.

Optional Feature:
Macro IOCTL_WB_MERGE_EN.
- Defined:
  - A one-entry merge register sits in front of the FIFO.
  - A write whose word address matches the held entry and whose sel is the complement of the held sel is merged: sel becomes 4'b1111, and the upper/lower data halves are taken from the respective writes. The merged entry is pushed.
  - A non-matching write pushes the held entry and takes its place in the register.
  - On the falling edge of ioctl_download, the held entry is flushed to the FIFO.
  - ioctl_wait accounts for the extra held slot.
- Undefined: every halfword produces its own Wishbone beat with 2-bit selects.

Decomposition:
- Shared package archie_loader_pkg holds:
  - the entry typedef (struct: adr, sel, dat);
  - the state enum {IDLE, WRITE};
  - the SEL_LO and SEL_HI constants.
- One sub-module, loader_fifo: a synchronous FIFO with count output, parameterised on FIFO_DEPTH and the entry width.
- The Wishbone FSM and the merge logic stay in the top module.

Test Plan:
1. Download window of 4 writes (addr 0x400000..0x400006, data 0x1111..0x4444), slave acking in the cycle after stb:
   - Without merge: 4 beats — adr 0x100000 sel 0011, adr 0x100000 sel 1100, adr 0x100001 sel 0011, adr 0x100001 sel 1100 — and beat_count = 4.
   - With IOCTL_WB_MERGE_EN: 2 beats with sel 1111, data 0x22221111 and 0x44443333.
2. Slave withholding ack for 20 cycles while ioctl_wr fires every cycle: ioctl_wait = 1 once count reaches 6. A HPS model that stalls on wait produces no overflow; all writes land in order.
3. Same stall scenario with a HPS model that ignores ioctl_wait: writes beyond 8 are dropped, overflow = 1, and overflow clears on the next download rising edge.
4. ioctl_download falls while 3 entries are queued: loader_busy stays 1 until the 3rd ack, then loader_done pulses exactly 1 cycle.
5. Reset asserted mid-beat (wb_cyc = 1, ack pending): wb_cyc = 0 without waiting for a clock edge, FIFO empty, beat_count = 0, and no loader_done pulse.
6. Push and pop in the same cycle with the FIFO full: the write is accepted, count stays 8, and overflow stays 0.
